// File: rtl/traffic_pkg.sv
// traffic_pkg: shared detector FSM states, default debounce/stuck limits and counter-width helper
package traffic_pkg;
  typedef enum logic [2:0] {IDLE, ARRIVE, OCCUPIED, LEAVE, STUCK} det_state_t;
  localparam int DB_CYCLES_DEF = 3;
  localparam int STUCK_CYCLES_DEF = 255;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser; CLK/RST_N clock and async active-low reset, d async input, q synchronised output
module sync_2ff (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/car_request_detector.sv
// car_request_detector: debounced loop sensor to Car request; Loop_Raw/Green_Side in, Car/Car_Count/Fault/Overflow registered out
module car_request_detector
  import traffic_pkg::*;
#(
  parameter int WL = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          Loop_Raw,
  input  logic          Green_Side,
  output logic          Car,
  output logic [WL-1:0] Car_Count,
  output logic          Fault,
  output logic          Overflow
);
  localparam int DW = cnt_w(DB_CYCLES);
  localparam int SW = cnt_w(STUCK_CYCLES + 1);
  localparam logic [WL-1:0] MAX = '1;
  det_state_t st, st_n;
  logic [DW-1:0] db, db_n, db1;
  logic [SW-1:0] sc, sc_n, sc1;
  logic s, db_done, arr, dep, fault_n, ovf_n;
  logic [WL-1:0] cnt_n;
  sync_2ff u_sync (.CLK(CLK), .RST_N(RST_N), .d(Loop_Raw), .q(s));
  assign db1 = db + DW'(1);
  assign sc1 = sc + SW'(1);
  assign db_done = db1 == DW'(DB_CYCLES);
  // db is zero on entry to IDLE, OCCUPIED and STUCK, so the first differing sample counts as 1
  always_comb begin
    st_n = st;
    db_n = db;
    sc_n = sc;
    arr = 1'b0;
    dep = 1'b0;
    case (st)
      IDLE, ARRIVE: begin
        if (!s) begin
          st_n = IDLE;
          db_n = '0;
        end else begin
          st_n = db_done ? OCCUPIED : ARRIVE;
          db_n = db_done ? '0 : db1;
          arr = db_done;
        end
      end
      OCCUPIED: begin
        sc_n = sc1;
        if (!s) begin
          st_n = db_done ? IDLE : LEAVE;
          db_n = db_done ? '0 : db1;
          dep = db_done;
          sc_n = db_done ? '0 : sc1;
        end else if (sc1 >= SW'(STUCK_CYCLES)) st_n = STUCK;
      end
      LEAVE, STUCK: begin
        if (s) begin
          db_n = '0;
          st_n = st == LEAVE ? OCCUPIED : STUCK;
        end else begin
          st_n = db_done ? IDLE : st;
          db_n = db_done ? '0 : db1;
          dep = db_done;
          sc_n = db_done ? '0 : sc;
        end
      end
      default: st_n = IDLE;
    endcase
  end
  assign cnt_n = arr && Car_Count != MAX ? Car_Count + WL'(1)
               : dep && Green_Side && Car_Count != '0 ? Car_Count - WL'(1)
               : Car_Count;
  assign ovf_n = Overflow | (arr && Car_Count == MAX);
  assign fault_n = st_n == STUCK;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      st <= IDLE;
      db <= '0;
      sc <= '0;
      Car_Count <= '0;
      Overflow <= 1'b0;
      Fault <= 1'b0;
      Car <= 1'b0;
    end else begin
      st <= st_n;
      db <= db_n;
      sc <= sc_n;
      Car_Count <= cnt_n;
      Overflow <= ovf_n;
      Fault <= fault_n;
      Car <= (cnt_n != '0) | fault_n;
    end
endmodule

// File: tb/tb_car_request_detector.sv
// tb_car_request_detector: directed vectors against a level/run-length model of the detector
module tb_car_request_detector;
  localparam int WL = 4;
  localparam int DB = 3;
  localparam int STK = 8;
  localparam int CMAX = 15;
  logic CLK, RST_N, Loop_Raw, Green_Side, Car, Fault, Overflow;
  logic [WL-1:0] Car_Count;
  int errors = 0, checks = 0;
  bit m1, m2, s_m, lvl, f_m, ovf_m, occ;
  int run, sc_m, cnt_m;
  car_request_detector #(.WL(WL), .DB_CYCLES(DB), .STUCK_CYCLES(STK)) dut (
    .CLK(CLK), .RST_N(RST_N), .Loop_Raw(Loop_Raw), .Green_Side(Green_Side),
    .Car(Car), .Car_Count(Car_Count), .Fault(Fault), .Overflow(Overflow)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      m1 = 0; m2 = 0; lvl = 0; f_m = 0; ovf_m = 0; run = 0; sc_m = 0; cnt_m = 0;
    end else begin
      s_m = m2;
      occ = lvl && !f_m && run == 0;
      run = s_m != lvl ? run + 1 : 0;
      if (occ) begin
        sc_m++;
        if (s_m && sc_m >= STK) f_m = 1;
      end
      if (run == DB) begin
        lvl = !lvl;
        run = 0;
        if (lvl) begin
          if (cnt_m < CMAX) cnt_m++;
          else ovf_m = 1;
        end else begin
          if (Green_Side && cnt_m > 0) cnt_m--;
          f_m = 0;
          sc_m = 0;
        end
      end
      m2 = m1;
      m1 = Loop_Raw;
    end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge CLK)
    if (RST_N) begin
      chk("model_count", int'(Car_Count), cnt_m);
      chk("model_fault", int'(Fault), int'(f_m));
      chk("model_car", int'(Car), int'(cnt_m != 0 || f_m));
      chk("model_ovf", int'(Overflow), int'(ovf_m));
    end
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic all_zero(input string nm);
    chk({nm, "_car"}, int'(Car), 0);
    chk({nm, "_count"}, int'(Car_Count), 0);
    chk({nm, "_fault"}, int'(Fault), 0);
    chk({nm, "_ovf"}, int'(Overflow), 0);
  endtask
  task automatic rst_pulse(input string nm);
    RST_N = 0;
    Loop_Raw = 0;
    #1;
    all_zero(nm);
    #1 RST_N = 1;
  endtask
  task automatic vehicle();
    Loop_Raw = 1;
    tick(6);
    Loop_Raw = 0;
    tick(6);
  endtask
  initial begin
    RST_N = 0;
    Loop_Raw = 0;
    Green_Side = 0;
    tick(2);
    all_zero("reset");
    RST_N = 1;
    tick(3);
    all_zero("post_reset");
    Loop_Raw = 1;
    tick(2);
    Loop_Raw = 0;
    tick(6);
    all_zero("glitch");
    Loop_Raw = 1;
    tick(4);
    chk("arr_edge4_count", int'(Car_Count), 0);
    chk("arr_edge4_car", int'(Car), 0);
    tick(1);
    chk("arr_edge5_count", int'(Car_Count), 1);
    chk("arr_edge5_car", int'(Car), 1);
    Loop_Raw = 0;
    tick(1);
    Loop_Raw = 1;
    tick(1);
    Loop_Raw = 0;
    tick(10);
    chk("dip_unserved_count", int'(Car_Count), 1);
    chk("dip_unserved_car", int'(Car), 1);
    Green_Side = 1;
    Loop_Raw = 1;
    tick(5);
    chk("served_arr_count", int'(Car_Count), 2);
    Loop_Raw = 0;
    tick(4);
    chk("served_pre_count", int'(Car_Count), 2);
    tick(1);
    chk("served_dep_count", int'(Car_Count), 1);
    tick(3);
    Green_Side = 0;
    vehicle();
    chk("unserved_count", int'(Car_Count), 2);
    rst_pulse("midop_reset");
    tick(1);
    for (int i = 1; i <= 16; i++) begin
      vehicle();
      if (i == 15) begin
        chk("sat15_count", int'(Car_Count), 15);
        chk("sat15_ovf", int'(Overflow), 0);
      end
      if (i == 16) begin
        chk("sat16_count", int'(Car_Count), 15);
        chk("sat16_ovf", int'(Overflow), 1);
      end
    end
    Green_Side = 1;
    vehicle();
    chk("sat_served_count", int'(Car_Count), 14);
    chk("sat_sticky_ovf", int'(Overflow), 1);
    Green_Side = 0;
    rst_pulse("sat_reset");
    tick(2);
    Loop_Raw = 1;
    tick(5);
    chk("stuck_e5_count", int'(Car_Count), 1);
    chk("stuck_e5_fault", int'(Fault), 0);
    tick(7);
    chk("stuck_e12_fault", int'(Fault), 0);
    tick(1);
    chk("stuck_e13_fault", int'(Fault), 1);
    chk("stuck_e13_car", int'(Car), 1);
    tick(17);
    Green_Side = 1;
    Loop_Raw = 0;
    tick(4);
    chk("stuck_pre_fault", int'(Fault), 1);
    chk("stuck_pre_count", int'(Car_Count), 1);
    tick(1);
    all_zero("stuck_clear");
    Green_Side = 0;
    Loop_Raw = 1;
    tick(13);
    chk("fault_before_reset", int'(Fault), 1);
    rst_pulse("fault_reset");
    tick(3);
    all_zero("fault_reset_after");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
